vec_store_unit: RTL
===================

# vec_store_unit

Vector store serializer for the vector CPU datapath. It accepts a full LANES×WIDTH result vector from the VecALU writeback path through a valid/ready handshake. It then writes the selected lanes, one word per cycle, to scalar-width data memory at consecutive addresses, and pulses `done` when the store completes.

## Interface
Parameters:
- `LANES`, default 16: number of vector lanes.
- `WIDTH`, default 16: bits per lane and per memory word.
- `ADDR_W`, default 16: memory address width.

Ports:
- `clk`, input, 1: single clock; everything samples on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `in_valid`, input, 1: a store request is present.
- `in_ready`, output, 1: the unit can accept a request.
- `in_data`, input, [LANES-1:0][WIDTH-1:0]: vector to store; lane 0 is written first.
- `in_base_addr`, input, ADDR_W: address for lane 0.
- `in_count`, input, $clog2(LANES+1): number of lanes to write, starting at lane 0.
- `mem_we`, output, 1: memory write strobe.
- `mem_addr`, output, ADDR_W: write address.
- `mem_wdata`, output, WIDTH: write data.
- `mem_ready`, input, 1: memory accepts the write in this cycle; low means stall.
- `busy`, output, 1: high in WRITE and DONE.
- `done`, output, 1: one-cycle pulse when the store completes.

## Operation
- Three states: IDLE, WRITE and DONE. All outputs are registered or decoded from the state register only; no input reaches an output combinationally.
- Reset (`reset`=0 at a clock edge) forces the following state on the next cycle:
  - state IDLE, `in_ready`=1;
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `busy`=0, `done`=0;
  - lane index 0 and all capture registers cleared.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, capture `in_data`, `in_base_addr` and the effective count, where effective count = min(`in_count`, LANES).
  - Effective count 0 goes to DONE and no write is issued. Otherwise go to WRITE with lane index 0.
- WRITE:
  - `in_ready`=0 and `mem_we`=1.
  - `mem_addr` = captured base + idx, truncated to ADDR_W, so the address wraps modulo 2^ADDR_W.
  - `mem_wdata` = captured lane[idx].
  - A write completes only in a cycle with `mem_ready`=1. The index then increments.
  - If the completed write had idx = count-1, go to DONE and drive `mem_we`=0 in the next cycle.
  - With `mem_ready`=0, `mem_we`, `mem_addr` and `mem_wdata` hold their values.
- DONE: `done`=1 for exactly one cycle, `in_ready`=0, `mem_we`=0; then go to IDLE.
- `in_valid` during WRITE or DONE is ignored. The upstream stage must hold the request until it is accepted.
- Changes on `in_data` after acceptance do not affect the store in progress.
- Reset asserted during WRITE aborts the store. No further `mem_we` is issued and `done` does not pulse.

## Timing
- Request accepted at edge T with count N≥1 and no stalls:
  - writes at cycles T+1 … T+N;
  - `done` at T+N+1;
  - `in_ready` high again at T+N+2.
- With N=0: `done` at T+1, `in_ready` at T+2.
- Each stall cycle (`mem_ready`=0 while `mem_we`=1) adds one cycle to all later events.
- Back-to-back requests have a minimum spacing of N+2 cycles.
- Throughput is one lane per cycle while `mem_ready` stays high.

## Test plan
- Basic store: in_data lanes 0..7 = 210,255,252,245,30,11,102,25; base 0x0040; count 8. Required: eight writes to 0x0040..0x0047 with those values, in lane order, in consecutive cycles; `done` one cycle after the last write; `in_ready` one cycle after that.
- Stalls: same vector with `mem_ready` low during the 3rd write for 2 cycles. Required: write 3 (addr 0x0042, data 252) held stable for 3 cycles, total 10 write cycles, no lane skipped or duplicated.
- Count boundaries:
  - count 0: no `mem_we`, `done` at T+1;
  - count 16: all lanes written;
  - count 17 (representable as $clog2(17)=5 bits): clamped to 16 writes.
- Address wrap: base 0xFFFE, count 4. Required addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Protocol and reset:
  - `in_valid` held high and `in_data` changed during WRITE: ignored, original data stored, second request accepted only after `done`.
  - Reset low during the 2nd write: next cycle `mem_we`=0, `in_ready`=1, `busy`=0, and no `done` pulse.

Source files
------------

// File: rtl/vec_store_unit.sv
// Vector store serializer: captures a LANES x WIDTH vector and writes the
// first N lanes, one word per cycle, to consecutive memory addresses.
module vec_store_unit #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES-1:0][WIDTH-1:0]      in_data,
  input  logic [ADDR_W-1:0]                in_base_addr,
  input  logic [$clog2(LANES+1)-1:0]       in_count,
  output logic                             mem_we,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [WIDTH-1:0]                 mem_wdata,
  input  logic                             mem_ready,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned CNT_W = $clog2(LANES + 1);
  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [LANES-1:0][WIDTH-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]             base_q, base_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [ADDR_W-1:0]             mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]              mem_wdata_q, mem_wdata_d;
  logic                          in_ready_q, in_ready_d;
  logic                          mem_we_q, mem_we_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic [CNT_W-1:0]              eff_count;
  logic [IDX_W-1:0]              idx_inc;
  logic                          last_lane;

  // Next-state, capture and write-port update
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    data_d      = data_q;
    base_d      = base_q;
    count_d     = count_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    eff_count = (in_count > CNT_W'(LANES)) ? CNT_W'(LANES) : in_count;
    idx_inc   = idx_q + IDX_W'(1);
    last_lane = (CNT_W'(idx_q) == (count_q - CNT_W'(1)));

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d      = in_data;
          base_d      = in_base_addr;
          count_d     = eff_count;
          idx_d       = '0;
          mem_addr_d  = in_base_addr;
          mem_wdata_d = in_data[0];
          state_d     = (eff_count == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        // Address/data only advance once memory has taken the current word
        if (mem_ready) begin
          if (last_lane) begin
            state_d = DONE;
          end else begin
            idx_d       = idx_inc;
            mem_addr_d  = base_q + ADDR_W'(idx_inc);
            mem_wdata_d = data_q[idx_inc];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    mem_we_d   = (state_d == WRITE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      data_q      <= '0;
      base_q      <= '0;
      count_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      base_q      <= base_d;
      count_q     <= count_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
